rf_rename_ckpt: RTL
===================

# rf_rename_ckpt

Parametrised successor to the architectural register file with dependency tags: a register value array plus per-register busy/tag (ROB index) table with NRD read ports, commit-time forwarding and NCKPT branch checkpoints of the tag table. It sits between the instruction unit (issue/operand read) and the ROB (commit, misprediction recovery), replacing the all-or-nothing clear with selective restore.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers (power of 2, ≥2); RW = log2(NREG)
- TAG_W, 4, ROB index width
- NRD, 2, read ports
- NCKPT, 4, checkpoint slots (power of 2); CW = log2(NCKPT)
- clk_in  in  1  clock; all state changes on rising edge
- rst_n_in  in  1  reset, asynchronous and active-low
- rdy_in  in  1  low: hold all state; reads stay live
- flush  in  1  clear busy on all live registers
- rd_id  in  NRD*RW  read register indices, port k at [k*RW +: RW]
- rd_val  out  NRD*XLEN  read values
- rd_tag  out  NRD*TAG_W  producing ROB tag
- rd_busy  out  NRD  operand still pending
- issue_valid  in  1; issue_rd  in  RW; issue_tag  in  TAG_W  rename rd to tag
- commit_valid  in  1; commit_rd  in  RW; commit_val  in  XLEN; commit_tag  in  TAG_W
- ckpt_save  in  1; ckpt_save_id  in  CW  snapshot tag table into slot
- ckpt_restore  in  1; ckpt_restore_id  in  CW  reload live tag table from slot

## Operation
- State: val[NREG], busy[NREG], tag[NREG]; per slot sbusy[NCKPT][NREG], stag[NCKPT][NREG].
- Register 0: reads return val 0, busy 0, tag 0; writes, issues, commits to 0 ignored.
- Read (combinational): val/busy/tag of rd_id from live table, pre-issue state. Forwarding: if commit_valid, commit_rd==rd_id≠0, busy and tag==commit_tag → rd_val=commit_val, rd_busy=0. Value forwarding only when tag matches; otherwise live val.
- Commit (commit_valid, rd≠0): val[rd]←commit_val unconditionally. busy[rd] cleared only if busy and tag[rd]==commit_tag. Same tag-match clear applied in every checkpoint slot (sbusy[s][rd] cleared if stag[s][rd]==commit_tag).
- Issue (issue_valid, rd≠0): busy[rd]←1, tag[rd]←issue_tag.
- Next-state priority on live busy/tag: flush > restore > issue > commit clear. Commit value write always happens (also under flush/restore).
- Restore: live busy/tag ← slot ckpt_restore_id, with this cycle's commit tag-match clear applied to the restored entry. Issue in the same cycle is dropped.
- Flush: all live busy←0, tag←0; slots untouched (except commit clears). Restore ignored.
- Save: slot ← next-state of live table (after commit, issue, restore, flush). Save with restore same slot: slot gets restored-then-committed content.
- rdy_in low: no state change of any kind; reads and forwarding remain combinational.

## Timing
- Reset (rst_n_in=0, async): val, busy, tag, sbusy, stag all 0; outputs show 0/0/0 immediately after assertion.
- Read latency 0 (combinational); issue/commit/restore visible to reads the cycle after the edge, commit value visible same cycle via forwarding.
- No handshake; every valid input is accepted in its cycle when rdy_in=1.
- Reset release mid-sequence: first edge after deassertion is normal operation.

## Test plan
- Reset then read x5 on both ports → val 0, busy 0, tag 0; write x0 via commit 0xDEAD → reads of x0 stay 0.
- Issue x3 tag 7; next cycle read x3 → busy 1, tag 7; commit x3 tag 7 val 0x1234 that cycle → rd_val 0x1234, busy 0 same cycle, and stored next cycle.
- Issue x3 tag 2, then tag 5; commit x3 tag 2 val 0x11 → val 0x11, busy stays 1, tag 5.
- Same cycle issue x4 tag 9 and commit x4 tag 9-old (tag 3 active) → busy 1, tag 9; read that cycle shows pre-issue tag 3 with forwarded value.
- Issue x6 tag 1, save slot 2, issue x6 tag 4, commit x6 tag 1 val 0xAA, restore slot 2 → x6 busy 0, val 0xAA; restore slot 2 again without commit → still busy 0.
- rdy_in low with issue x7 tag 6 and flush → no change; flush with rdy high after issues to x1,x2 → all busy 0, slots retain snapshots.

Source files
------------

// File: rtl/rf_rename_ckpt.sv
// Register file with per-register busy/tag rename table, commit-time forwarding
// and NCKPT branch checkpoints of the tag table for selective misprediction recovery.
`timescale 1ns / 1ps
module rf_rename_ckpt #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NCKPT = 4,
    localparam int unsigned RW   = $clog2(NREG),
    localparam int unsigned CW   = $clog2(NCKPT)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic [NRD*RW-1:0]     rd_id,
    output logic [NRD*XLEN-1:0]   rd_val,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  issue_valid,
    input  logic [RW-1:0]         issue_rd,
    input  logic [TAG_W-1:0]      issue_tag,
    input  logic                  commit_valid,
    input  logic [RW-1:0]         commit_rd,
    input  logic [XLEN-1:0]       commit_val,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic                  ckpt_save,
    input  logic [CW-1:0]         ckpt_save_id,
    input  logic                  ckpt_restore,
    input  logic [CW-1:0]         ckpt_restore_id
);

    logic [XLEN-1:0]  val_q   [NREG];
    logic [XLEN-1:0]  val_d   [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];
    logic [NREG-1:0]  sbusy_q [NCKPT];
    logic [NREG-1:0]  sbusy_d [NCKPT];
    logic [TAG_W-1:0] stag_q  [NCKPT][NREG];
    logic [TAG_W-1:0] stag_d  [NCKPT][NREG];

    logic [NREG-1:0]  commit_hit;

    always_comb begin
        commit_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            commit_hit[r] = commit_valid && (commit_rd == RW'(r));
        end
    end

    // Reads see the pre-issue live table; a matching commit forwards its value.
    always_comb begin
        logic [RW-1:0] id;
        rd_val  = '0;
        rd_tag  = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            id = rd_id[k*RW +: RW];
            if (id != '0) begin
                rd_val[k*XLEN +: XLEN]   = val_q[id];
                rd_tag[k*TAG_W +: TAG_W] = tag_q[id];
                rd_busy[k]               = busy_q[id];
                if (commit_hit[id] && busy_q[id] && (tag_q[id] == commit_tag)) begin
                    rd_val[k*XLEN +: XLEN] = commit_val;
                    rd_busy[k]             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        val_d   = val_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        sbusy_d = sbusy_q;
        stag_d  = stag_q;
        for (int r = 1; r < NREG; r++) begin
            if (commit_hit[r]) begin
                val_d[r] = commit_val;
            end
            if (flush) begin
                busy_d[r] = 1'b0;
                tag_d[r]  = '0;
            end else if (ckpt_restore) begin
                busy_d[r] = sbusy_q[ckpt_restore_id][r] &&
                            !(commit_hit[r] && (stag_q[ckpt_restore_id][r] == commit_tag));
                tag_d[r]  = stag_q[ckpt_restore_id][r];
            end else if (issue_valid && (issue_rd == RW'(r))) begin
                busy_d[r] = 1'b1;
                tag_d[r]  = issue_tag;
            end else if (commit_hit[r] && (tag_q[r] == commit_tag)) begin
                busy_d[r] = 1'b0;
            end
            for (int s = 0; s < NCKPT; s++) begin
                if (commit_hit[r] && (stag_q[s][r] == commit_tag)) begin
                    sbusy_d[s][r] = 1'b0;
                end
            end
        end
        // Snapshot the fully resolved next live table, overriding the slot's own clear.
        if (ckpt_save) begin
            sbusy_d[ckpt_save_id] = busy_d;
            stag_d[ckpt_save_id]  = tag_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            val_q   <= '{default: '0};
            busy_q  <= '0;
            tag_q   <= '{default: '0};
            sbusy_q <= '{default: '0};
            stag_q  <= '{default: '0};
        end else if (rdy_in) begin
            val_q   <= val_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            sbusy_q <= sbusy_d;
            stag_q  <= stag_d;
        end
    end

endmodule
